env_slot_sequencer: RTL
=======================

# env_slot_sequencer

Time-multiplexed envelope scheduler for the piano voice engine. It steps through all voices in fixed slots and fetches each voice's rate word from the envelope parameter ROM. It drives the exponent shifter (4-bit shift code plus 13-bit mantissa in, 19-bit step out) and accumulates or decays the per-voice envelope level with saturation. It sits between the key-event front end and the amplitude multiplier, and is the only master of the shifter and the envelope ROM.

## Interface
- VOICES, 16: voice count; power of two.
- ENV_W, 19: envelope level width; matches shifter output.
- SUSTAIN_LVL, 19'h20000: level at which DECAY hands over to SUSTAIN.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_valid  in  1  key event offered
- key_ready  out  1  event accepted when valid&ready
- key_on  in  1  1 = key-on, 0 = key-off
- key_voice  in  4  target voice
- rom_rd  out  1  ROM read strobe
- rom_addr  out  6  {phase[1:0], voice[3:0]}
- rom_data  in  17  {shift[3:0], mant[12:0]}; valid the cycle after rom_rd
- sh_bus  out  4  shift code to shifter
- sh_mant  out  13  mantissa to shifter
- sh_step  in  19  combinational shifter result for current sh_bus/sh_mant
- env_valid  out  1  one-cycle pulse per slot
- env_voice  out  4  voice of env_level
- env_level  out  19  updated level

## Operation
- Slot = 4 cycles (S0..S3); frame = VOICES×4 = 64 cycles; voice index = slot counter, wraps 15→0.
- S0: read voice state (phase, level) from state RAM. rom_rd=1, rom_addr={phase, voice}.
- S1: register rom_data. sh_bus/sh_mant driven from that register; held through S2.
- S2: register sh_step as step.
- S3: compute next state, write back, pulse env_valid with new level.
- Phases: IDLE(0), ATTACK(1), DECAY(2), SUSTAIN(3); RELEASE is encoded as DECAY with rel flag set.
- Transitions at S3:
  - ATTACK: level+step. If the sum is ≥ 2^19−1, clamp to 7FFFF and go to DECAY.
  - DECAY: level−step. If the result is ≤ SUSTAIN_LVL, clamp to SUSTAIN_LVL and go to SUSTAIN.
  - SUSTAIN: hold.
  - RELEASE: level−step. If it borrows or reaches 0, level=0 and go to IDLE.
  - IDLE: hold 0.
- Arithmetic is 20-bit internally. Carry and borrow are checked; stored level never wraps.
- Key events:
  - key_ready=1 whenever out of reset. An accepted event sets pend_on[v] or pend_off[v].
  - Pending bits are consumed at that voice's next S3 and override the phase transition.
  - Key-on: level=0, phase=ATTACK, rel=0. Key-off: rel=1, phase=DECAY (no effect if IDLE).
  - Both pending on the same voice: key-on wins; both bits are cleared.
  - Event accepted in the same cycle as that voice's S3: not applied that cycle; applied next frame.

## Timing
- Reset values:
  - Outputs: all 0, except key_ready which is 0 only while rst_n=0.
  - Internal: slot counter 0 (voice 0, S0); state RAM all IDLE/0; pending bits 0.
- After rst_n deasserts:
  - First rom_rd in the first cycle.
  - First env_valid in cycle 3, for voice 0; thereafter every 4 cycles.
- Key event to first level change: at most 64+4 cycles.
- Reset mid-frame aborts the slot with no write-back.

## Configuration
- ENV_STATUS_EN defined: adds output active_mask[VOICES-1:0]. Bit v is set when voice v is not IDLE, updated at v's S3, reset 0.
- Undefined: port and its logic are absent; all other behaviour is identical.

## Structure
- Package env_seq_pkg holds:
  - phase_t enum;
  - ENV_W, MANT_W=13, SHIFT_W=4, SLOT_CYCLES=4;
  - ENV_MAX=19'h7FFFF.
- Sub-module env_state_ram: VOICES×(ENV_W+3) register file, one async read, one sync write, reset to 0.

## Test plan
- Reset, no keys → env_valid every 4 cycles with voices 0,1,…,15,0 and env_level=0.
- Key-on voice 3; ROM attack word gives step 0x00100 → voice 3 level 0x100, 0x200, 0x300 on successive frames, 64 cycles apart.
- Attack with step 0x40000 → 0x40000, then 0x7FFFF clamped with phase DECAY. The next decay with step 0x70000 clamps to SUSTAIN_LVL 0x20000, then holds.
- Key-off from level 0x50000, release step 0x30000 → 0x20000, then 0 and IDLE, with no wrap.
- Key-on and key-off for voice 5 in back-to-back cycles before its S3 → voice 5 enters ATTACK at level 0.
- rst_n low at cycle 37 → outputs 0 immediately. After release, env_valid resumes for voice 0 at cycle 3 and all levels read 0.

Source files
------------

// File: rtl/env_seq_pkg.sv
// Shared types and constants for the envelope slot sequencer.
package env_seq_pkg;
    localparam int VOICES      = 16;
    localparam int VOICE_W     = 4;
    localparam int ENV_W       = 19;
    localparam int MANT_W      = 13;
    localparam int SHIFT_W     = 4;
    localparam int SLOT_CYCLES = 4;
    localparam logic [ENV_W-1:0] ENV_MAX = 19'h7FFFF;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_ATTACK  = 2'd1,
        PH_DECAY   = 2'd2,
        PH_SUSTAIN = 2'd3
    } phase_t;

    typedef enum logic [$clog2(SLOT_CYCLES)-1:0] {S0, S1, S2, S3} stage_t;

    typedef struct packed {
        logic              rel;
        phase_t            phase;
        logic [ENV_W-1:0]  level;
    } voice_state_t;
endpackage

// File: rtl/env_state_ram.sv
// Per-voice envelope state: one async read port, one sync write port, cleared on reset.
module env_state_ram
    import env_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VOICE_W-1:0] rd_addr,
    output voice_state_t       rd_data,
    input  logic               wr_en,
    input  logic [VOICE_W-1:0] wr_addr,
    input  voice_state_t       wr_data
);
    voice_state_t mem [VOICES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VOICES; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/env_slot_sequencer.sv
// Time-multiplexed envelope scheduler; ENV_STATUS_EN adds the active_mask status output.
// stage | meaning
// S0    | read voice state, strobe envelope ROM
// S1    | capture ROM rate word, drive shifter
// S2    | capture shifter step
// S3    | compute next state, write back, pulse env_valid
module env_slot_sequencer
    import env_seq_pkg::*;
#(
    parameter logic [ENV_W-1:0] SUSTAIN_LVL = 19'h20000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_valid,
    output logic                       key_ready,
    input  logic                       key_on,
    input  logic [VOICE_W-1:0]         key_voice,
    output logic                       rom_rd,
    output logic [VOICE_W+1:0]         rom_addr,
    input  logic [SHIFT_W+MANT_W-1:0]  rom_data,
    output logic [SHIFT_W-1:0]         sh_bus,
    output logic [MANT_W-1:0]          sh_mant,
    input  logic [ENV_W-1:0]           sh_step,
    output logic                       env_valid,
    output logic [VOICE_W-1:0]         env_voice,
    output logic [ENV_W-1:0]           env_level
`ifdef ENV_STATUS_EN
    ,
    output logic [VOICES-1:0]          active_mask
`endif
);
    localparam logic [VOICES-1:0] ONE = VOICES'(1);

    stage_t                      stage_q, stage_d;
    logic [VOICE_W-1:0]          voice_q, voice_d;
    logic [SHIFT_W+MANT_W-1:0]   rate_q;
    logic [ENV_W-1:0]            step_q;
    logic [VOICES-1:0]           pend_on_q, pend_off_q, consume, set_mask;
    voice_state_t                cur, nxt;
    logic [ENV_W:0]              sum, diff;

    env_state_ram u_state_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (voice_q),
        .rd_data (cur),
        .wr_en   (stage_q == S3),
        .wr_addr (voice_q),
        .wr_data (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= S0;
            voice_q <= '0;
            rate_q  <= '0;
            step_q  <= '0;
        end else begin
            stage_q <= stage_d;
            voice_q <= voice_d;
            if (stage_q == S1) rate_q <= rom_data;
            if (stage_q == S2) step_q <= sh_step;
        end
    end

    always_comb begin
        stage_d = stage_q;
        voice_d = voice_q;
        case (stage_q)
            S0: stage_d = S1;
            S1: stage_d = S2;
            S2: stage_d = S3;
            S3: begin
                stage_d = S0;
                voice_d = voice_q + 4'd1;
            end
        endcase
    end

    always_comb begin
        sum  = {1'b0, cur.level} + {1'b0, step_q};
        diff = {1'b0, cur.level} - {1'b0, step_q};
        nxt  = cur;
        case (cur.phase)
            PH_IDLE: begin
                nxt.level = '0;
                nxt.rel   = 1'b0;
            end
            PH_ATTACK: begin
                if (sum >= {1'b0, ENV_MAX}) begin
                    nxt.level = ENV_MAX;
                    nxt.phase = PH_DECAY;
                end else begin
                    nxt.level = sum[ENV_W-1:0];
                end
            end
            PH_DECAY: begin
                // rel turns DECAY into RELEASE: fall through sustain all the way to zero
                if (cur.rel) begin
                    if (diff[ENV_W] || diff[ENV_W-1:0] == '0) begin
                        nxt.level = '0;
                        nxt.phase = PH_IDLE;
                        nxt.rel   = 1'b0;
                    end else begin
                        nxt.level = diff[ENV_W-1:0];
                    end
                end else if (diff[ENV_W] || diff[ENV_W-1:0] <= SUSTAIN_LVL) begin
                    nxt.level = SUSTAIN_LVL;
                    nxt.phase = PH_SUSTAIN;
                end else begin
                    nxt.level = diff[ENV_W-1:0];
                end
            end
            PH_SUSTAIN: nxt.level = cur.level;
        endcase
        if (pend_on_q[voice_q]) begin
            nxt.level = '0;
            nxt.phase = PH_ATTACK;
            nxt.rel   = 1'b0;
        end else if (pend_off_q[voice_q] && cur.phase != PH_IDLE) begin
            nxt       = cur;
            nxt.phase = PH_DECAY;
            nxt.rel   = 1'b1;
        end
    end

    // A new event in the consuming cycle wins over the clear, so it lands next frame.
    assign consume  = (stage_q == S3) ? (ONE << voice_q) : '0;
    assign set_mask = (key_valid && key_ready) ? (ONE << key_voice) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_on_q  <= '0;
            pend_off_q <= '0;
        end else begin
            pend_on_q  <= (pend_on_q  & ~consume) | (set_mask & {VOICES{key_on}});
            pend_off_q <= (pend_off_q & ~consume) | (set_mask & {VOICES{~key_on}});
        end
    end

    assign key_ready = rst_n;
    assign rom_rd    = rst_n && (stage_q == S0);
    assign rom_addr  = rom_rd ? {cur.phase, voice_q} : '0;
    assign sh_bus    = rate_q[SHIFT_W+MANT_W-1:MANT_W];
    assign sh_mant   = rate_q[MANT_W-1:0];
    assign env_valid = rst_n && (stage_q == S3);
    assign env_voice = env_valid ? voice_q : '0;
    assign env_level = env_valid ? nxt.level : '0;

`ifdef ENV_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_mask <= '0;
        end else if (stage_q == S3) begin
            active_mask[voice_q] <= (nxt.phase != PH_IDLE);
        end
    end
`endif
endmodule
